// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - phase sequencer and cpu/dma arbiter for one SRAM macro
//
// Purpose: grants one of two requesters (cpu, dma) per access and walks the
// macro through IDLE -> PCH -> ACT(xSENSE_CYC) -> XFER -> DONE, driving the
// precharge, wordline, column, write and output-enable controls. Every control
// output is a register that is updated on the edge entering the state it belongs to.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      cpu request (level, held until cpu_ack), addr = {row,col}
//   cpu_ack                    one-cycle completion pulse
//   dma_*                      same as cpu_*
//   rdata                      read data, valid in the ack cycle, held until the next read
//   n_pch, n_wl_pch            bitline / decoder precharge, active low
//   wl_ena                     wordline enable
//   row_d, row_nd              row address true / complement
//   col                        one-hot column select, zero when idle
//   wr, lane_wdata             lane write-driver enable and the data driven
//   oe, n_oe                   lane output enable and its complement
//   lane_rdata                 lane data bus, sampled at the end of XFER
module sram_access_ctrl #(
    parameter int ROW_BITS  = 5,
    parameter int COL_BITS  = 2,
    parameter int DATA_W    = 8,
    parameter int SENSE_CYC = 1,
    parameter int DMA_PRIO  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ROW_BITS+COL_BITS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic                         cpu_ack,
    input  logic                         dma_req,
    input  logic                         dma_we,
    input  logic [ROW_BITS+COL_BITS-1:0] dma_addr,
    input  logic [DATA_W-1:0]            dma_wdata,
    output logic                         dma_ack,
    output logic [DATA_W-1:0]            rdata,
    output logic                         n_pch,
    output logic                         n_wl_pch,
    output logic                         wl_ena,
    output logic [ROW_BITS-1:0]          row_d,
    output logic [ROW_BITS-1:0]          row_nd,
    output logic [(1<<COL_BITS)-1:0]     col,
    output logic                         wr,
    output logic                         oe,
    output logic                         n_oe,
    output logic [DATA_W-1:0]            lane_wdata,
    input  logic [DATA_W-1:0]            lane_rdata
);

    localparam int A    = ROW_BITS + COL_BITS;
    localparam int NCOL = 1 << COL_BITS;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PCH  = 3'd1,
        S_ACT  = 3'd2,
        S_XFER = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                state_q;
    logic [2:0]            cnt_q;
    logic                  we_q;
    logic                  owner_q;     // 1: dma owns the current access
    logic                  rr_q;        // 1: dma wins the next tie (round-robin mode)
    logic [COL_BITS-1:0]   col_addr_q;
    logic                  n_pch_q;
    logic                  n_wl_pch_q;
    logic                  wl_ena_q;
    logic [ROW_BITS-1:0]   row_q;
    logic [NCOL-1:0]       col_q;
    logic                  wr_q;
    logic                  oe_q;
    logic [DATA_W-1:0]     lane_wdata_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  cpu_ack_q;
    logic                  dma_ack_q;

    logic                  contested;
    logic                  grant_dma;
    logic                  win_we;
    logic [A-1:0]          win_addr;
    logic [DATA_W-1:0]     win_wdata;

    // Arbitration is only acted on in IDLE; the result is ignored elsewhere.
    always_comb begin
        contested = cpu_req & dma_req;
        grant_dma = dma_req;
        if (contested) begin
            grant_dma = (DMA_PRIO != 0) ? 1'b1 : rr_q;
        end
        win_we    = grant_dma ? dma_we    : cpu_we;
        win_addr  = grant_dma ? dma_addr  : cpu_addr;
        win_wdata = grant_dma ? dma_wdata : cpu_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            rr_q         <= 1'b0;
            col_addr_q   <= '0;
            n_pch_q      <= 1'b0;
            n_wl_pch_q   <= 1'b0;
            wl_ena_q     <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            wr_q         <= 1'b0;
            oe_q         <= 1'b0;
            lane_wdata_q <= '0;
            rdata_q      <= '0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_req | dma_req) begin
                        owner_q      <= grant_dma;
                        we_q         <= win_we;
                        row_q        <= win_addr[A-1:COL_BITS];
                        col_addr_q   <= win_addr[COL_BITS-1:0];
                        lane_wdata_q <= win_wdata;
                        // Loser of a tie is favoured next time; uncontested grants leave the pointer alone.
                        if (contested && DMA_PRIO == 0) begin
                            rr_q <= ~grant_dma;
                        end
                        state_q <= S_PCH;
                    end
                end
                S_PCH: begin
                    n_pch_q    <= 1'b1;
                    n_wl_pch_q <= 1'b1;
                    wl_ena_q   <= 1'b1;
                    col_q      <= {{(NCOL-1){1'b0}}, 1'b1} << col_addr_q;
                    cnt_q      <= 3'(SENSE_CYC - 1);
                    state_q    <= S_ACT;
                end
                S_ACT: begin
                    if (cnt_q == 3'd0) begin
                        wr_q    <= we_q;
                        oe_q    <= ~we_q;
                        state_q <= S_XFER;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_XFER: begin
                    // Wordline drops in the same edge that precharge returns, so the two never overlap.
                    wr_q       <= 1'b0;
                    oe_q       <= 1'b0;
                    wl_ena_q   <= 1'b0;
                    col_q      <= '0;
                    n_pch_q    <= 1'b0;
                    n_wl_pch_q <= 1'b0;
                    if (!we_q) begin
                        rdata_q <= lane_rdata;
                    end
                    cpu_ack_q <= ~owner_q;
                    dma_ack_q <= owner_q;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign dma_ack    = dma_ack_q;
    assign rdata      = rdata_q;
    assign n_pch      = n_pch_q;
    assign n_wl_pch   = n_wl_pch_q;
    assign wl_ena     = wl_ena_q;
    assign row_d      = row_q;
    assign row_nd     = ~row_q;
    assign col        = col_q;
    assign wr         = wr_q;
    assign oe         = oe_q;
    assign n_oe       = ~oe_q;
    assign lane_wdata = lane_wdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(wl_ena_q && !n_pch_q));
            assert (!(wr_q && oe_q));
            assert ($countones(col_q) <= 1);
            assert (!(wr_q || oe_q) || state_q == S_XFER);
            assert (!(cpu_ack_q && dma_ack_q));
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - scoreboard bench for sram_access_ctrl
module tb_sram_access_ctrl;

    localparam int NI = 3;   // 0: SENSE 1 DMA prio, 1: SENSE 1 round-robin, 2: SENSE 3 DMA prio

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req [NI];
    logic       cpu_we [NI];
    logic [6:0] cpu_addr [NI];
    logic [7:0] cpu_wdata [NI];
    logic       cpu_ack [NI];
    logic       dma_req [NI];
    logic       dma_we [NI];
    logic [6:0] dma_addr [NI];
    logic [7:0] dma_wdata [NI];
    logic       dma_ack [NI];
    logic [7:0] rdata [NI];
    logic       n_pch [NI];
    logic       n_wl_pch [NI];
    logic       wl_ena [NI];
    logic [4:0] row_d [NI];
    logic [4:0] row_nd [NI];
    logic [3:0] col [NI];
    logic       wr [NI];
    logic       oe [NI];
    logic       n_oe [NI];
    logic [7:0] lane_wdata [NI];
    logic [7:0] lane_rdata [NI];

    logic [7:0] mem [NI][128] = '{default: '{default: 8'h00}};

    typedef struct {
        int       inst;
        bit       dma;
        bit       rd;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    bit   t6_on  = 1'b0;
    int   t6_last = -1;
    int   t6_npch = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sram_access_ctrl #(
            .ROW_BITS(5), .COL_BITS(2), .DATA_W(8),
            .SENSE_CYC(g == 2 ? 3 : 1),
            .DMA_PRIO(g == 1 ? 0 : 1)
        ) u_dut (
            .clk(clk), .reset(reset),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_ack(cpu_ack[g]),
            .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_addr(dma_addr[g]),
            .dma_wdata(dma_wdata[g]), .dma_ack(dma_ack[g]),
            .rdata(rdata[g]), .n_pch(n_pch[g]), .n_wl_pch(n_wl_pch[g]), .wl_ena(wl_ena[g]),
            .row_d(row_d[g]), .row_nd(row_nd[g]), .col(col[g]), .wr(wr[g]), .oe(oe[g]),
            .n_oe(n_oe[g]), .lane_wdata(lane_wdata[g]), .lane_rdata(lane_rdata[g])
        );
    end

    function automatic logic [1:0] col_idx(input logic [3:0] c);
        case (c)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Lane/array model: writes land mid-XFER, reads are driven while oe is high.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            lane_rdata[i] = oe[i] ? mem[i][{row_d[i], col_idx(col[i])}] : 8'h00;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (wr[i]) mem[i][{row_d[i], col_idx(col[i])}] = lane_wdata[i];
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on every ack.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (row_nd[i] !== ~row_d[i] || n_oe[i] !== ~oe[i] || (wr[i] && oe[i]) ||
                    (wl_ena[i] && !n_pch[i]) || $countones(col[i]) > 1 || (cpu_ack[i] && dma_ack[i])) begin
                    fails++;
                    $display("FAIL invariant inst%0d: row_d=%h row_nd=%h oe=%b n_oe=%b wr=%b wl=%b n_pch=%b col=%b acks=%b%b",
                             i, row_d[i], row_nd[i], oe[i], n_oe[i], wr[i], wl_ena[i], n_pch[i], col[i], cpu_ack[i], dma_ack[i]);
                end
                if (cpu_ack[i] || dma_ack[i]) begin
                    exp_t e;
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_ack inst%0d: cpu_ack=%b dma_ack=%b, none required", i, cpu_ack[i], dma_ack[i]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.inst != i || e.dma != dma_ack[i] || (e.rd && rdata[i] !== e.data)) begin
                            fails++;
                            $display("FAIL ack_order: got inst%0d dma=%b rdata=%h, required inst%0d dma=%b rd=%b data=%h",
                                     i, dma_ack[i], rdata[i], e.inst, e.dma, e.rd, e.data);
                        end
                    end
                    if (i == 2 && t6_on) begin
                        if (t6_last >= 0) begin
                            checks++;
                            if (cyc - t6_last != 7 || t6_npch < 1) begin
                                fails++;
                                $display("FAIL b2b_interval: got %0d cycles, n_pch low %0d, required 7 and >=1",
                                         cyc - t6_last, t6_npch);
                            end
                        end
                        t6_last = cyc;
                        t6_npch = 0;
                    end
                end else if (i == 2 && t6_on && !n_pch[i]) begin
                    t6_npch++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic set_req(input int i, input bit d, input bit v);
        if (d) dma_req[i] = v;
        else   cpu_req[i] = v;
    endtask

    task automatic set_cmd(input int i, input bit d, input bit we, input logic [6:0] a, input logic [7:0] w);
        if (d) begin dma_we[i] = we; dma_addr[i] = a; dma_wdata[i] = w; end
        else   begin cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = w; end
    endtask

    task automatic push_exp(input int i, input bit d, input bit rd, input logic [7:0] data);
        exp_t e;
        e.inst = i; e.dma = d; e.rd = rd; e.data = data;
        exp_q.push_back(e);
    endtask

    // Holds req for n back-to-back accesses, dropping it in the last ack cycle.
    task automatic requester(input int i, input bit d, input int n);
        int cnt = 0;
        int budget = 300;
        set_req(i, d, 1'b1);
        while (cnt < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (d ? dma_ack[i] : cpu_ack[i]) begin
                cnt++;
                if (cnt == n) set_req(i, d, 1'b0);
            end
        end
        checks++;
        if (cnt < n) begin
            fails++;
            set_req(i, d, 1'b0);
            $display("FAIL requester_timeout inst%0d dma=%b: got %0d acks required %0d", i, d, cnt, n);
        end
    endtask

    // One access issued in an IDLE cycle (k=1); records per-cycle observations.
    task automatic single_access(input int i, input bit d, input bit we, input logic [6:0] a,
                                 input logic [7:0] w, input logic [7:0] rd_exp,
                                 output int ack_k, output int wr_n, output int oe_n,
                                 output logic [4:0] row2, output logic [3:0] col3, output int wr_k);
        ack_k = 0; wr_n = 0; oe_n = 0; row2 = '0; col3 = '0; wr_k = 0;
        @(posedge clk); #1;
        set_cmd(i, d, we, a, w);
        push_exp(i, d, !we, rd_exp);
        set_req(i, d, 1'b1);
        for (int k = 1; k <= 40 && ack_k == 0; k++) begin
            @(negedge clk);
            if (wr[i]) begin wr_n++; wr_k = k; end
            if (oe[i]) oe_n++;
            if (k == 2) row2 = row_d[i];
            if (k == 3) col3 = col[i];
            if (cpu_ack[i] || dma_ack[i]) begin
                ack_k = k;
                set_req(i, d, 1'b0);
            end
        end
        if (ack_k == 0) begin
            set_req(i, d, 1'b0);
            check("single_access_timeout", 32'(ack_k), 32'd1);
        end
    endtask

    task automatic check_reset(input int i);
        check("rst_n_pch", n_pch[i], 1'b0);
        check("rst_n_wl_pch", n_wl_pch[i], 1'b0);
        check("rst_wl_ena", wl_ena[i], 1'b0);
        check("rst_col", col[i], 4'h0);
        check("rst_wr", wr[i], 1'b0);
        check("rst_oe", oe[i], 1'b0);
        check("rst_n_oe", n_oe[i], 1'b1);
        check("rst_acks", {cpu_ack[i], dma_ack[i]}, 2'b00);
        check("rst_rdata", rdata[i], 8'h00);
        check("rst_row_d", row_d[i], 5'h00);
        check("rst_row_nd", row_nd[i], 5'h1f);
        check("rst_lane_wdata", lane_wdata[i], 8'h00);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_k, wr_n, oe_n, wr_k;
        logic [4:0] row2;
        logic [3:0] col3;

        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            cpu_req[i] = 0; dma_req[i] = 0;
            set_cmd(i, 0, 0, 7'h00, 8'h00);
            set_cmd(i, 1, 0, 7'h00, 8'h00);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check_reset(i);
        reset = 1'b0;

        // cpu write 0x25 <- 0xA5
        single_access(0, 0, 1, 7'h25, 8'hA5, 8'h00, ack_k, wr_n, oe_n, row2, col3, wr_k);
        check("wr_ack_cycle", ack_k, 5);
        check("wr_row_d", row2, 5'h09);
        check("wr_col", col3, 4'b0010);
        check("wr_pulse_count", wr_n, 1);
        check("wr_pulse_cycle", wr_k, 4);

        // cpu read 0x25 returns 0xA5
        single_access(0, 0, 0, 7'h25, 8'h00, 8'hA5, ack_k, wr_n, oe_n, row2, col3, wr_k);
        check("rd_ack_cycle", ack_k, 5);
        check("rd_oe_count", oe_n, 1);
        check("rd_no_wr", wr_n, 0);
        check("rd_rdata_held", rdata[0], 8'hA5);

        // reset held 3 cycles mid-ACT: no ack, controls back to reset values
        @(posedge clk); #1;
        set_cmd(0, 0, 0, 7'h25, 8'h00);
        cpu_req[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_act_wl_ena", wl_ena[0], 1'b1);
        reset = 1'b1;
        cpu_req[0] = 1'b0;
        @(posedge clk); #1;
        check_reset(0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        check("post_reset_idle_wl", wl_ena[0], 1'b0);
        check("post_reset_idle_pch", n_pch[0], 1'b0);

        // DMA priority: 3 dma reads, then 3 cpu writes
        for (int k = 0; k < 3; k++) push_exp(0, 1, 1, 8'hA5);
        for (int k = 0; k < 3; k++) push_exp(0, 0, 0, 8'h00);
        @(posedge clk); #1;
        set_cmd(0, 1, 0, 7'h25, 8'h00);
        set_cmd(0, 0, 1, 7'h11, 8'h3C);
        fork
            requester(0, 1, 3);
            requester(0, 0, 3);
        join
        single_access(0, 1, 0, 7'h11, 8'h00, 8'h3C, ack_k, wr_n, oe_n, row2, col3, wr_k);
        check("prio_readback_ack", ack_k, 5);

        // Round-robin: cpu, dma, cpu, dma, then a lone cpu request goes straight through
        push_exp(1, 0, 0, 8'h00);
        push_exp(1, 1, 1, 8'h42);
        push_exp(1, 0, 0, 8'h00);
        push_exp(1, 1, 1, 8'h42);
        @(posedge clk); #1;
        set_cmd(1, 0, 1, 7'h01, 8'h42);
        set_cmd(1, 1, 0, 7'h01, 8'h00);
        fork
            requester(1, 0, 2);
            requester(1, 1, 2);
        join
        single_access(1, 0, 0, 7'h01, 8'h00, 8'h42, ack_k, wr_n, oe_n, row2, col3, wr_k);
        check("rr_single_ack_cycle", ack_k, 5);

        // SENSE_CYC=3: row 31 col 3, then back-to-back reads every 7 cycles
        single_access(2, 0, 1, 7'h7F, 8'hC3, 8'h00, ack_k, wr_n, oe_n, row2, col3, wr_k);
        check("s3_ack_cycle", ack_k, 7);
        check("s3_row_d", row2, 5'h1f);
        check("s3_wr_cycle", wr_k, 6);
        for (int k = 0; k < 3; k++) push_exp(2, 0, 1, 8'hC3);
        @(posedge clk); #1;
        t6_on = 1'b1;
        t6_last = -1;
        set_cmd(2, 0, 0, 7'h7F, 8'h00);
        requester(2, 0, 3);
        t6_on = 1'b0;

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
